// File: rtl/adc_sequencer_pkg.sv
// ============================================================================
// Package  : adc_sequencer_pkg
// Brief    : Shared state encoding, ADC field widths and aux word packing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_sequencer_pkg;

    localparam int c_ch_w         = 5;
    localparam int c_data_w       = 12;
    localparam int c_aux_w        = 32;
    localparam int c_aux_ch_lsb   = 16;
    localparam int c_aux_data_lsb = 0;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CMD_AUDIO  = 3'd1,
        S_WAIT_AUDIO = 3'd2,
        S_AUX_SEL    = 3'd3,
        S_CMD_AUX    = 3'd4,
        S_WAIT_AUX   = 3'd5
    } state_t;

    function automatic logic [c_aux_w-1:0] pack_aux(
        input logic [c_ch_w-1:0]   ch,
        input logic [c_data_w-1:0] data
    );
        logic [c_aux_w-1:0] r;
        r = '0;
        r[c_aux_ch_lsb +: c_ch_w]     = ch;
        r[c_aux_data_lsb +: c_data_w] = data;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_sequencer_rr_picker.sv
// ============================================================================
// Module   : adc_sequencer_rr_picker
// Brief    : Finds the next enabled aux index strictly after the last one, with wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_sequencer_rr_picker #(
    parameter int COUNT = 4,
    parameter int IDX_W = 2
) (
    input  logic [COUNT-1:0] i_mask,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    int w_cand;

    // Walk from the farthest candidate down to the nearest so the nearest wins.
    always_comb begin
        o_idx   = i_last;
        o_found = 1'b0;
        w_cand  = 0;
        for (int k = COUNT; k >= 1; k--) begin
            w_cand = int'(i_last) + k;
            if (w_cand >= COUNT) begin
                w_cand = w_cand - COUNT;
            end
            if (i_mask[IDX_W'(w_cand)]) begin
                o_idx   = IDX_W'(w_cand);
                o_found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/adc_sequencer.sv
// ============================================================================
// Module   : adc_sequencer
// Brief    : Periodic audio + round-robin aux scheduler for the on-chip ADC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_sequencer
    import adc_sequencer_pkg::*;
#(
    parameter int AUDIO_CHANNEL = 1,
    parameter int AUX_BASE      = 2,
    parameter int AUX_COUNT     = 4,
    parameter int AUDIO_PERIOD  = 200,
    parameter int TIMEOUT       = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_in,
    input  logic [AUX_COUNT-1:0] aux_mask_in,
    input  logic                 status_clear_in,
    output logic                 command_valid,
    output logic [c_ch_w-1:0]    command_channel,
    output logic                 command_startofpacket,
    output logic                 command_endofpacket,
    input  logic                 command_ready,
    input  logic                 response_valid,
    input  logic [c_ch_w-1:0]    response_channel,
    input  logic [c_data_w-1:0]  response_data,
    output logic [c_data_w-1:0]  audio_out,
    output logic                 audio_stb_out,
    output logic [c_aux_w-1:0]   aux_out,
    output logic                 aux_stb_out,
    input  logic                 aux_ack_in,
    output logic                 overrun_out,
    output logic                 timeout_out
);

    localparam int c_idx_w = (AUX_COUNT > 1) ? $clog2(AUX_COUNT) : 1;
    localparam int c_per_w = $clog2(AUDIO_PERIOD);
    localparam int c_tmr_w = $clog2(TIMEOUT) + 1;
    localparam logic [c_ch_w-1:0] c_audio_ch = c_ch_w'(AUDIO_CHANNEL);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_per_w-1:0]   r_period_cnt;
    logic                 r_pending;
    logic [c_tmr_w-1:0]   r_timer;
    logic [c_idx_w-1:0]   r_rr_idx;
    logic [c_idx_w-1:0]   r_cur_idx;
    logic [c_data_w-1:0]  r_audio;
    logic                 r_audio_stb;
    logic [c_aux_w-1:0]   r_aux;
    logic                 r_aux_stb;
    logic                 r_overrun;
    logic                 r_timeout;

    logic [c_idx_w-1:0]   w_pick_idx;
    logic                 w_pick_found;
    logic [c_ch_w-1:0]    w_aux_ch;
    logic                 w_tick;
    logic                 w_timer_exp;
    logic                 w_consume;
    logic                 w_audio_hit;
    logic                 w_aux_hit;
    logic                 w_mismatch;
    logic                 w_expire;

    adc_sequencer_rr_picker #(
        .COUNT (AUX_COUNT),
        .IDX_W (c_idx_w)
    ) u_rr_picker (
        .i_mask  (aux_mask_in),
        .i_last  (r_rr_idx),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_aux_ch    = c_ch_w'(AUX_BASE) + c_ch_w'(r_cur_idx);
    assign w_tick      = run_in && (r_period_cnt == c_per_w'(AUDIO_PERIOD - 1));
    assign w_timer_exp = (r_timer == c_tmr_w'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_consume   = 1'b0;
        w_audio_hit = 1'b0;
        w_aux_hit   = 1'b0;
        w_mismatch  = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending && run_in) begin
                    w_consume   = 1'b1;
                    w_state_nxt = S_CMD_AUDIO;
                end
            end
            S_CMD_AUDIO: begin
                if (command_ready) w_state_nxt = S_WAIT_AUDIO;
            end
            S_WAIT_AUDIO: begin
                if (response_valid && response_channel == c_audio_ch) begin
                    w_audio_hit = 1'b1;
                    w_state_nxt = run_in ? S_AUX_SEL : S_IDLE;
                end else begin
                    w_mismatch = response_valid;
                    if (w_timer_exp) begin
                        w_expire    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_AUX_SEL: begin
                // An unacked aux result blocks the slot rather than being overwritten.
                if (run_in && w_pick_found && !r_aux_stb) w_state_nxt = S_CMD_AUX;
                else                                      w_state_nxt = S_IDLE;
            end
            S_CMD_AUX: begin
                if (command_ready) w_state_nxt = S_WAIT_AUX;
            end
            S_WAIT_AUX: begin
                if (response_valid && response_channel == w_aux_ch) begin
                    w_aux_hit   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_mismatch = response_valid;
                    if (w_timer_exp) begin
                        w_expire    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_period_cnt <= '0;
            r_pending    <= 1'b0;
            r_timer      <= '0;
            r_rr_idx     <= '0;
            r_cur_idx    <= '0;
            r_audio      <= '0;
            r_audio_stb  <= 1'b0;
            r_aux        <= '0;
            r_aux_stb    <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (!run_in || w_tick) r_period_cnt <= '0;
            else                   r_period_cnt <= r_period_cnt + c_per_w'(1);

            r_pending <= run_in && (w_tick || (r_pending && !w_consume));

            if (r_state == S_CMD_AUDIO || r_state == S_CMD_AUX) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT_AUDIO || r_state == S_WAIT_AUX) begin
                r_timer <= r_timer + c_tmr_w'(1);
            end

            if (r_state == S_AUX_SEL) r_cur_idx <= w_pick_idx;
            // A timed-out aux still counts as issued so a dead channel cannot starve the rest.
            if (w_aux_hit || (r_state == S_WAIT_AUX && w_expire)) r_rr_idx <= r_cur_idx;

            r_audio_stb <= w_audio_hit;
            if (w_audio_hit) r_audio <= response_data;

            if (w_aux_hit) begin
                r_aux     <= pack_aux(response_channel, response_data);
                r_aux_stb <= 1'b1;
            end else if (aux_ack_in) begin
                r_aux_stb <= 1'b0;
            end

            if (w_tick && r_pending && !w_consume) r_overrun <= 1'b1;
            else if (status_clear_in)              r_overrun <= 1'b0;

            if (w_mismatch || w_expire) r_timeout <= 1'b1;
            else if (status_clear_in)   r_timeout <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(w_aux_hit && r_aux_stb));
        end
    end
`endif

    assign command_valid         = (r_state == S_CMD_AUDIO) || (r_state == S_CMD_AUX);
    assign command_channel       = (r_state == S_CMD_AUDIO) ? c_audio_ch :
                                   (r_state == S_CMD_AUX)   ? w_aux_ch   : '0;
    assign command_startofpacket = command_valid;
    assign command_endofpacket   = command_valid;
    assign audio_out             = r_audio;
    assign audio_stb_out         = r_audio_stb;
    assign aux_out               = r_aux;
    assign aux_stb_out           = r_aux_stb;
    assign overrun_out           = r_overrun;
    assign timeout_out           = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_adc_sequencer.sv
// ============================================================================
// Module   : tb_adc_sequencer
// Brief    : Scoreboard bench with an ADC response model and a CPU ack model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_sequencer;

    localparam int AUDIO_CH = 1;
    localparam int LAT      = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_in = 1'b0;
    logic [3:0]  aux_mask_in = 4'b0000;
    logic        status_clear_in = 1'b0;
    logic        command_valid;
    logic [4:0]  command_channel;
    logic        command_startofpacket;
    logic        command_endofpacket;
    logic        command_ready = 1'b0;
    logic        response_valid = 1'b0;
    logic [4:0]  response_channel = 5'd0;
    logic [11:0] response_data = 12'd0;
    logic [11:0] audio_out;
    logic        audio_stb_out;
    logic [31:0] aux_out;
    logic        aux_stb_out;
    logic        aux_ack_in = 1'b0;
    logic        overrun_out;
    logic        timeout_out;

    adc_sequencer u_dut (
        .clk                   (clk),
        .rst                   (rst),
        .run_in                (run_in),
        .aux_mask_in           (aux_mask_in),
        .status_clear_in       (status_clear_in),
        .command_valid         (command_valid),
        .command_channel       (command_channel),
        .command_startofpacket (command_startofpacket),
        .command_endofpacket   (command_endofpacket),
        .command_ready         (command_ready),
        .response_valid        (response_valid),
        .response_channel      (response_channel),
        .response_data         (response_data),
        .audio_out             (audio_out),
        .audio_stb_out         (audio_stb_out),
        .aux_out               (aux_out),
        .aux_stb_out           (aux_stb_out),
        .aux_ack_in            (aux_ack_in),
        .overrun_out           (overrun_out),
        .timeout_out           (timeout_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [11:0] data;
        int          cyc;
    } aud_exp_t;

    aud_exp_t    q_aud[$];
    logic [31:0] q_aux[$];

    // Bench configuration, changed only by the sequencing process just after a rising edge.
    bit cfg_ready    = 1'b1;
    bit cfg_withhold = 1'b0;
    bit auto_ack     = 1'b0;
    int phase        = 0;

    int n_audio_cmd  = 0;
    int n_aux_cmd    = 0;
    int n_audio_stb  = 0;
    int n_aux_load   = 0;
    int last_aud_acc = -1;
    int acc_cyc      = 0;
    int aux_p2       = 0;
    bit m_acc        = 1'b0;
    bit m_busy       = 1'b0;
    int m_cnt        = 0;
    logic [4:0]  m_ch = 5'd0;
    logic [11:0] m_d  = 12'd0;

    // ADC model: drives on the falling edge, one command outstanding, fixed latency.
    initial begin : adc_model
        forever begin
            @(negedge clk);
            response_valid = 1'b0;
            m_acc          = 1'b0;
            command_ready  = cfg_ready;
            if (rst) begin
                m_busy = 1'b0;
            end else begin
                if (m_busy) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_busy = 1'b0;
                        if (!(cfg_withhold && m_ch == 5'(AUDIO_CH))) begin
                            m_d              = 12'($urandom);
                            response_valid   = 1'b1;
                            response_channel = m_ch;
                            response_data    = m_d;
                            if (m_ch == 5'(AUDIO_CH)) q_aud.push_back('{m_d, cyc + 1});
                            else                      q_aux.push_back({11'b0, m_ch, 4'b0, m_d});
                        end
                    end
                end
                if (command_valid && command_ready) begin
                    m_busy  = 1'b1;
                    m_cnt   = LAT;
                    m_ch    = command_channel;
                    m_acc   = 1'b1;
                    acc_cyc = cyc + 1;
                    if (m_ch == 5'(AUDIO_CH)) begin
                        if (phase == 1 && last_aud_acc >= 0) check("audio_period", acc_cyc - last_aud_acc, 200);
                        last_aud_acc = acc_cyc;
                        n_audio_cmd++;
                    end else begin
                        n_aux_cmd++;
                        if (phase == 2) begin
                            check("aux_rr_channel", m_ch, (aux_p2 % 2 == 0) ? 32'd3 : 32'd5);
                            aux_p2++;
                        end
                    end
                end
            end
        end
    end

    bit         prev_stb   = 1'b0;
    bit         prev_valid = 1'b0;
    logic [4:0] prev_ch    = 5'd0;
    aud_exp_t   e_aud;

    // Output monitor and CPU model, sampling 1 time unit after each rising edge.
    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_stb   = 1'b0;
                prev_valid = 1'b0;
                aux_ack_in = 1'b0;
            end else begin
                if (audio_stb_out) begin
                    n_audio_stb++;
                    check("audio_expected", 32'(q_aud.size() != 0), 1);
                    if (q_aud.size() != 0) begin
                        e_aud = q_aud.pop_front();
                        check("audio_data", audio_out, e_aud.data);
                        check("audio_latency", cyc, e_aud.cyc);
                    end
                end
                if (aux_stb_out && !prev_stb) begin
                    n_aux_load++;
                    check("aux_expected", 32'(q_aux.size() != 0), 1);
                    if (q_aux.size() != 0) check("aux_out", aux_out, q_aux.pop_front());
                end
                if (prev_valid && !m_acc) begin
                    check("cmd_valid_held", command_valid, 1);
                    check("cmd_channel_stable", command_channel, prev_ch);
                end
                check("sop_eop", {command_startofpacket, command_endofpacket}, {command_valid, command_valid});
                prev_stb   = aux_stb_out;
                prev_valid = command_valid;
                prev_ch    = command_channel;
                aux_ack_in = auto_ack && aux_stb_out;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_audio_acc(input int budget);
        int start = n_audio_cmd;
        int k = 0;
        while (n_audio_cmd == start && k < budget) begin
            tick(1);
            k++;
        end
        check("wait_audio_cmd", 32'(n_audio_cmd != start), 1);
    endtask

    task automatic wait_aux_acc(input int budget);
        int start = n_aux_cmd;
        int k = 0;
        while (n_aux_cmd == start && k < budget) begin
            tick(1);
            k++;
        end
        check("wait_aux_cmd", 32'(n_aux_cmd != start), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   command_valid, 0);
        check({tag, "_channel"}, command_channel, 0);
        check({tag, "_audio"},   audio_out, 0);
        check({tag, "_astb"},    audio_stb_out, 0);
        check({tag, "_aux"},     aux_out, 0);
        check({tag, "_xstb"},    aux_stb_out, 0);
        check({tag, "_overrun"}, overrun_out, 0);
        check({tag, "_timeout"}, timeout_out, 0);
    endtask

    int s_a;
    int s_b;
    int s_c;
    int k_to;

    initial begin : sequencer
        rst = 1'b1;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(2);

        // Audio only: one command every period, no aux traffic.
        phase       = 1;
        run_in      = 1'b1;
        aux_mask_in = 4'b0000;
        auto_ack    = 1'b1;
        wait_audio_acc(300);
        s_a = n_audio_stb;
        s_b = n_aux_cmd;
        tick(800);
        check("p1_audio_strobes", n_audio_stb - s_a, 4);
        check("p1_no_aux_cmds", n_aux_cmd - s_b, 0);

        // Two enabled aux channels, immediate ack: alternate 3,5.
        wait_audio_acc(300);
        phase       = 2;
        aux_mask_in = 4'b1010;
        s_a = n_aux_cmd;
        s_b = n_aux_load;
        tick(800);
        check("p2_aux_cmds", n_aux_cmd - s_a, 4);
        check("p2_aux_loads", n_aux_load - s_b, 4);

        // All enabled, never acked: one aux result, later slots skipped.
        wait_audio_acc(300);
        phase       = 3;
        aux_mask_in = 4'b1111;
        auto_ack    = 1'b0;
        s_a = n_aux_cmd;
        s_b = n_audio_stb;
        tick(600);
        check("p3_one_aux_cmd", n_aux_cmd - s_a, 1);
        check("p3_audio_strobes", n_audio_stb - s_b, 3);
        check("p3_aux_stb_held", aux_stb_out, 1);

        // Withheld audio response: timeout 64 clocks after accept.
        wait_audio_acc(300);
        phase           = 4;
        cfg_withhold    = 1'b1;
        aux_mask_in     = 4'b0000;
        auto_ack        = 1'b1;
        status_clear_in = 1'b1;
        tick(1);
        status_clear_in = 1'b0;
        check("p4_timeout_clear", timeout_out, 0);
        k_to = 0;
        while (!timeout_out && k_to < 100) begin
            tick(1);
            k_to++;
        end
        check("p4_timeout_set", timeout_out, 1);
        check("p4_timeout_cycle", cyc - acc_cyc, 64);
        cfg_withhold = 1'b0;
        check("p4_aux_acked", aux_stb_out, 0);
        wait_audio_acc(300);
        s_a = n_audio_stb;
        tick(20);
        check("p4_recovered_audio", n_audio_stb - s_a, 1);
        check("p4_no_overrun", overrun_out, 0);

        // Stalled command port across two ticks: overrun, then one pending command.
        tick(150);
        phase     = 5;
        cfg_ready = 1'b0;
        s_a = n_audio_cmd;
        tick(450);
        check("p5_overrun", overrun_out, 1);
        check("p5_stalled_valid", command_valid, 1);
        check("p5_no_accepts", n_audio_cmd - s_a, 0);
        cfg_ready = 1'b1;
        s_a = n_audio_cmd;
        s_b = n_audio_stb;
        tick(60);
        check("p5_pending_cmds", n_audio_cmd - s_a, 2);
        check("p5_pending_strobes", n_audio_stb - s_b, 2);
        status_clear_in = 1'b1;
        tick(1);
        status_clear_in = 1'b0;
        tick(1);
        check("p5_overrun_cleared", overrun_out, 0);
        check("p5_timeout_cleared", timeout_out, 0);

        // run_in drops while an aux conversion is outstanding.
        phase       = 6;
        aux_mask_in = 4'b0001;
        wait_aux_acc(400);
        run_in = 1'b0;
        s_a = n_aux_load;
        s_b = n_audio_cmd;
        s_c = n_aux_cmd;
        tick(500);
        check("p6_aux_completed", n_aux_load - s_a, 1);
        check("p6_no_audio_cmds", n_audio_cmd - s_b, 0);
        check("p6_no_aux_cmds", n_aux_cmd - s_c, 0);
        check("p6_idle_valid", command_valid, 0);

        // Reset while an aux conversion is outstanding.
        run_in = 1'b1;
        wait_aux_acc(600);
        rst = 1'b1;
        tick(15);
        check_all_zero("midrst");
        rst = 1'b0;
        tick(2);
        check_all_zero("postrst");
        check("audio_queue_empty", q_aud.size(), 0);
        check("aux_queue_empty", q_aux.size(), 0);
        run_in = 1'b0;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
